mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the ERM16 single-port memory bus between up to N_REQ masters: CPU fetch/data path, the stack16_sync engine, and an I/O/DMA port. It replaces the combinational `stack_owns_bus` mux with a registered req/gnt arbiter that adds a bounded hold time and bus locking. It sits between the master ports and ADDR_BUS/DO/DI/wrmem at the top level.

## Interface
- N_REQ, 3: number of requesters; index 0 is highest priority (stack = 0, CPU = 1, DMA = 2).
- AW, 16: address width.
- DW, 16: data width.
- MAX_HOLD, 8: maximum consecutive granted cycles before a forced release when others are waiting; must be at least 1.

Ports (reset rst, synchronous, active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-master bus request; level.
- lock  in  N_REQ  per-master lock; suppresses forced release while owner.
- m_addr  in  N_REQ*AW  packed master addresses; slice i = master i.
- m_wdata  in  N_REQ*DW  packed master write data.
- m_we  in  N_REQ  per-master write enable.
- gnt  out  N_REQ  registered one-hot grant; at most one bit set.
- rvalid  out  N_REQ  one-cycle pulse; the read data for master i is on rdata.
- rdata  out  DW  registered copy of mem_rdata.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DW  synchronous memory read data; valid one cycle after the address.

## Operation
- States: IDLE (no owner) and OWN (owner index `own` is valid, gnt[own] = 1).
- Every cycle in OWN is one transfer. Outputs are combinational from the owner slice: mem_addr = m_addr[own], mem_wdata = m_wdata[own], mem_we = m_we[own] & req[own].
- In IDLE: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- A read is a granted cycle with m_we = 0 and req = 1. rvalid[own_prev] pulses the next cycle, and rdata = mem_rdata is latched at that edge.
- IDLE → OWN: at the edge after any req bit is high, own ← winner and the hold counter ← 1.
- Release condition in OWN:
  - req[own] = 0, or
  - hold == MAX_HOLD while any other req is high and lock[own] = 0.
- At release:
  - If another master requests, own ← winner, chosen from masters other than the old owner, and hold ← 1. There is no dead cycle, so gnt moves directly to the new winner.
  - If the owner dropped req and no other master requests, go to IDLE.
  - If the release was forced by MAX_HOLD, the old owner is ineligible at that edge.
- Holding: otherwise in OWN, hold increments and saturates at MAX_HOLD.
- Lock: lock[own] = 1 keeps ownership indefinitely while req[own] = 1. lock on a non-owner has no effect.
- Simultaneous events:
  - Owner deassertion takes precedence over the hold count.
  - A new higher-priority req never pre-empts a current owner before release, in either priority mode.
- Reset mid-operation: at the reset edge, gnt = 0, rvalid = 0, rdata = 0, own = 0, hold = 0, state = IDLE. A pending read response is discarded.

## Timing
- Arbitration latency: a req seen at edge k produces gnt at edge k+1, when the bus is IDLE or being released.
- Read latency: rdata and rvalid arrive one cycle after the granted read cycle. Back-to-back reads by one owner give one rvalid per cycle.
- Writes commit in the granted cycle; there is no response.
- A master must hold req, m_addr, m_we and m_wdata stable until it sees gnt. Each cycle with gnt = 1 and req = 1 consumes one transfer.
- Reset values: gnt = 0, rvalid = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: the winner is the first requesting index after the last owner, scanning cyclically modulo N_REQ. The pointer resets to N_REQ-1, so master 0 wins first.
  - Undefined: fixed priority, lowest index wins. MAX_HOLD forced release still excludes the old owner for that one arbitration.

## Structure
- Package `erm16_bus_pkg`:
  - State enum `arb_state_t` (IDLE, OWN).
  - Default AW/DW localparams.
  - Requester index constants REQ_STACK = 0, REQ_CPU = 1, REQ_DMA = 2.
- Sub-module `arb_pick`: combinational winner select. Inputs: req mask, exclude mask, last-owner pointer (round-robin only). Outputs: index and any-valid flag.
- The top level instantiates mem_bus_arbiter in place of the stack_owns_bus mux.

## Test plan
- Reset and single read: rst for 2 cycles, then req = 3'b010 with m_addr[1] = 16'h0040. Expect gnt = 3'b010 one cycle later with mem_addr = 16'h0040, then rvalid = 3'b010 with rdata = mem_rdata the next cycle.
- Priority: req = 3'b110 from IDLE. Expect gnt = 3'b010 (CPU). When CPU drops req, gnt = 3'b100 at the next edge with no idle cycle.
- MAX_HOLD = 4: CPU holds req with lock = 0 and DMA requests. Expect 4 CPU grants, then gnt = 3'b100. In round-robin and in fixed priority the CPU is excluded for that edge.
- Lock: the same as the MAX_HOLD scenario with lock[1] = 1. Expect CPU to keep gnt for 10+ cycles. After CPU drops req, DMA is granted the next edge.
- Round-robin (ARB_ROUND_ROBIN_EN): req = 3'b111 continuously with single-cycle owners (each master pulses req low after one grant). Expect the grant sequence 0, 1, 2, 0.
- Reset mid-read: assert rst in the cycle after a granted read. Expect rvalid = 0 and gnt = 0 at the next edge, and mem_we = 0.

Source files
------------

// File: rtl/erm16_bus_pkg.sv
// Shared types and constants for the ERM16 memory-bus arbiter.
package erm16_bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    localparam int REQ_STACK = 0;
    localparam int REQ_CPU   = 1;
    localparam int REQ_DMA   = 2;

    // Index width that still works for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side and arbiter-side bundle for the shared ERM16 memory bus.
interface mem_bus_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int AW    = 16,
    parameter int DW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*AW-1:0] m_addr;
    logic [N_REQ*DW-1:0] m_wdata;
    logic [N_REQ-1:0]    m_we;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_we;
    logic [DW-1:0]       mem_rdata;

    modport master (
        output req, lock, m_addr, m_wdata, m_we, mem_rdata,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req, lock, m_addr, m_wdata, m_we, mem_rdata,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner select for the bus arbiter.
// ARB_ROUND_ROBIN_EN selects cyclic scan after the last owner; otherwise lowest index wins.
module arb_pick
    import erm16_bus_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_excl,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0]    i_last,
`endif
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [N_REQ-1:0] w_cand;
    logic [IW-1:0]    w_pos;

    assign w_cand = i_req & ~i_excl;

`ifdef ARB_ROUND_ROBIN_EN
    // Cyclic scan starting just after the previous owner; first hit wins.
    always_comb begin
        o_idx   = {IW{1'b0}};
        o_valid = 1'b0;
        w_pos   = {IW{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            w_pos   = IW'((int'(i_last) + k) % N_REQ);
            o_idx   = (!o_valid && w_cand[w_pos]) ? w_pos : o_idx;
            o_valid = o_valid | w_cand[w_pos];
        end
    end
`else
    // Downward scan so the lowest requesting index is the last one written.
    always_comb begin
        o_idx   = {IW{1'b0}};
        o_valid = 1'b0;
        w_pos   = {IW{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos   = IW'(k);
            o_idx   = w_cand[w_pos] ? w_pos : o_idx;
            o_valid = o_valid | w_cand[w_pos];
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Registered req/gnt arbiter for the ERM16 single-port memory bus with bounded hold and lock.
// Build option: ARB_ROUND_ROBIN_EN (round-robin winner select instead of fixed priority).
module mem_bus_arbiter
    import erm16_bus_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = 8
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int IW = idx_width(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t       r_state;
    logic [IW-1:0]    r_own;
    logic [HW-1:0]    r_hold;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_rvalid;
    logic [DW-1:0]    r_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]    r_last;
`endif

    logic [N_REQ-1:0] w_own_mask;
    logic [N_REQ-1:0] w_pick_mask;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_owner_req;
    logic             w_others;
    logic             w_forced;
    logic             w_release;
    logic             w_read;

    assign w_own_mask  = (r_state == OWN) ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_own) : {N_REQ{1'b0}};
    assign w_pick_mask = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_owner_req = (r_state == OWN) && bus.req[r_own];
    assign w_others    = |(bus.req & ~w_own_mask);
    // Lock only suppresses the hold-limit release; dropping req always releases.
    assign w_forced    = (r_hold == HW'(MAX_HOLD)) && w_others && !bus.lock[r_own];
    assign w_release   = !w_owner_req || w_forced;
    assign w_read      = w_owner_req && !bus.m_we[r_own];

    // The outgoing owner is never a candidate, which also covers the forced-release case.
    arb_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req   (bus.req),
        .i_excl  (w_own_mask),
`ifdef ARB_ROUND_ROBIN_EN
        .i_last  (r_last),
`endif
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Bus drive from the current owner's slice; quiet when no one owns the bus.
    always_comb begin
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = {DW{1'b0}};
        bus.mem_we    = 1'b0;
        if (r_state == OWN) begin
            bus.mem_addr  = bus.m_addr[r_own*AW +: AW];
            bus.mem_wdata = bus.m_wdata[r_own*DW +: DW];
            bus.mem_we    = bus.m_we[r_own] & bus.req[r_own];
        end else begin
            bus.mem_we    = 1'b0;
        end
    end

    // Arbitration FSM, hold counter and read-response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_own    <= {IW{1'b0}};
            r_hold   <= {HW{1'b0}};
            r_gnt    <= {N_REQ{1'b0}};
            r_rvalid <= {N_REQ{1'b0}};
            r_rdata  <= {DW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            r_last   <= IW'(N_REQ - 1);
`endif
        end else begin
            if (w_read) begin
                r_rvalid <= w_own_mask;
                r_rdata  <= bus.mem_rdata;
            end else begin
                r_rvalid <= {N_REQ{1'b0}};
                r_rdata  <= r_rdata;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= OWN;
                        r_own   <= w_pick_idx;
                        r_hold  <= HW'(1);
                        r_gnt   <= w_pick_mask;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last  <= w_pick_idx;
`endif
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= {N_REQ{1'b0}};
                    end
                end
                OWN: begin
                    if (w_release && w_pick_valid) begin
                        r_own   <= w_pick_idx;
                        r_hold  <= HW'(1);
                        r_gnt   <= w_pick_mask;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last  <= w_pick_idx;
`endif
                    end else if (w_release) begin
                        r_state <= IDLE;
                        r_own   <= {IW{1'b0}};
                        r_hold  <= {HW{1'b0}};
                        r_gnt   <= {N_REQ{1'b0}};
                    end else if (r_hold != HW'(MAX_HOLD)) begin
                        r_hold  <= r_hold + HW'(1);
                    end else begin
                        r_hold  <= r_hold;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_own   <= {IW{1'b0}};
                    r_hold  <= {HW{1'b0}};
                    r_gnt   <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MAX_HOLD = 4), one task per scenario.
module tb_mem_bus_arbiter;
    import erm16_bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.N_REQ(3), .AW(16), .DW(16)) bus ();

    mem_bus_arbiter #(
        .N_REQ    (3),
        .AW       (16),
        .DW       (16),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [15:0] a, input logic [15:0] d, input logic we);
        bus.m_addr[i*16 +: 16]  = a;
        bus.m_wdata[i*16 +: 16] = d;
        bus.m_we[i]             = we;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 3'b000;
        bus.lock = 3'b000;
        bus.m_we = 3'b000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = 3'b000; bus.lock = 3'b000; bus.m_we = 3'b000;
        bus.m_addr = 48'h0; bus.m_wdata = 48'h0; bus.mem_rdata = 16'h0;
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b want 000", bus.rvalid); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", bus.rdata); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got %h want 0000", bus.mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_m(REQ_CPU, 16'h0040, 16'h0000, 1'b0);
        bus.mem_rdata = 16'hBEEF;
        bus.req = 3'b010;
        step();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL read_gnt got %b want 010", bus.gnt); end
        checks++; if (bus.mem_addr !== 16'h0040) begin errors++; $display("FAIL read_addr got %h want 0040", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL read_we got %b want 0", bus.mem_we); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL read_rvalid_early got %b want 000", bus.rvalid); end
        step();
        checks++; if (bus.rvalid !== 3'b010) begin errors++; $display("FAIL read_rvalid got %b want 010", bus.rvalid); end
        checks++; if (bus.rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata got %h want beef", bus.rdata); end
        bus.req = 3'b000;
        step();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL read_release got %b want 000", bus.gnt); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL read_rvalid_end got %b want 000", bus.rvalid); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL read_idle_addr got %h want 0000", bus.mem_addr); end
    endtask

    task automatic test_priority();
        do_reset();
        set_m(REQ_CPU, 16'h1111, 16'h0000, 1'b0);
        set_m(REQ_DMA, 16'h2222, 16'hA5A5, 1'b1);
        bus.req = 3'b110;
        step();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL prio_gnt got %b want 010", bus.gnt); end
        checks++; if (bus.mem_addr !== 16'h1111) begin errors++; $display("FAIL prio_addr got %h want 1111", bus.mem_addr); end
        bus.req = 3'b100;
        step();
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL prio_handoff got %b want 100", bus.gnt); end
        checks++; if (bus.mem_addr !== 16'h2222) begin errors++; $display("FAIL prio_dma_addr got %h want 2222", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL prio_dma_we got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 16'hA5A5) begin errors++; $display("FAIL prio_dma_wdata got %h want a5a5", bus.mem_wdata); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL prio_rvalid got %b want 000", bus.rvalid); end
        bus.req = 3'b000;
        step();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL prio_idle got %b want 000", bus.gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL prio_idle_we got %b want 0", bus.mem_we); end
    endtask

    task automatic test_max_hold();
        do_reset();
        set_m(REQ_CPU, 16'h0100, 16'h0000, 1'b0);
        set_m(REQ_DMA, 16'h0200, 16'h0000, 1'b0);
        bus.lock = 3'b000;
        bus.req = 3'b110;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL hold_cpu[%0d] got %b want 010", i, bus.gnt); end
        end
        step();
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL hold_forced got %b want 100", bus.gnt); end
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_lock();
        do_reset();
        set_m(REQ_CPU, 16'h0100, 16'h0000, 1'b0);
        set_m(REQ_DMA, 16'h0200, 16'h0000, 1'b0);
        bus.lock = 3'b010;
        bus.req = 3'b110;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL lock_cpu[%0d] got %b want 010", i, bus.gnt); end
        end
        bus.req = 3'b100;
        step();
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL lock_release got %b want 100", bus.gnt); end
        bus.lock = 3'b000;
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_gnt = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
        do_reset();
        set_m(REQ_STACK, 16'h0010, 16'h0000, 1'b0);
        set_m(REQ_CPU,   16'h0020, 16'h0000, 1'b0);
        set_m(REQ_DMA,   16'h0030, 16'h0000, 1'b0);
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.gnt !== exp_gnt[i]) begin errors++; $display("FAIL rr_seq[%0d] got %b want %b", i, bus.gnt, exp_gnt[i]); end
            bus.req = 3'b111 & ~exp_gnt[i];
        end
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(REQ_CPU, 16'h0080, 16'h5A5A, 1'b0);
        bus.mem_rdata = 16'h1234;
        bus.req = 3'b010;
        step();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL mid_gnt got %b want 010", bus.gnt); end
        step();
        checks++; if (bus.rdata !== 16'h1234) begin errors++; $display("FAIL mid_rdata got %h want 1234", bus.rdata); end
        rst = 1'b1;
        bus.m_we[REQ_CPU] = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL mid_we_pre got %b want 1", bus.mem_we); end
        step();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL mid_rst_gnt got %b want 000", bus.gnt); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL mid_rst_rvalid got %b want 000", bus.rvalid); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL mid_rst_rdata got %h want 0000", bus.rdata); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL mid_rst_addr got %h want 0000", bus.mem_addr); end
        rst = 1'b0;
        bus.req = 3'b000;
        bus.m_we = 3'b000;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_max_hold();
        test_lock();
        test_round_robin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
